// File: rtl/user_level_pkg.sv
// Shared types and constants for the party-member level/XP tracker.
package user_level_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    CHECK,
    EVO_CHECK,
    EVOLVE
  } state_e;

  localparam logic [3:0]  MAX_LEVEL    = 4'd15;
  localparam int unsigned XP_PER_LEVEL = 16;

  // XP needed to leave level lvl; only evaluated below MAX_LEVEL, so it fits in 8 bits.
  function automatic logic [7:0] threshold(input logic [3:0] lvl);
    return 8'(32'(lvl) * XP_PER_LEVEL);
  endfunction

endpackage

// File: rtl/user_level_tracker.sv
// Level/XP tracker: accepts XP awards, levels up one step per CHECK pass, requests evolution.
// Optional EVOLVE_CANCEL_EN adds evolve_cancel and a block flag suppressing re-requests.
module user_level_tracker
  import user_level_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load_en,
  input  logic [4:0] load_ID,
  input  logic [3:0] load_level,
  input  logic       xp_valid,
  input  logic [7:0] xp_amount,
  output logic       xp_ready,
  input  logic [4:0] evo_ID,
  input  logic       evolve_ack,
`ifdef EVOLVE_CANCEL_EN
  input  logic       evolve_cancel,
`endif
  output logic [3:0] curr_level,
  output logic [4:0] curr_ID,
  output logic       level_up,
  output logic       evolve_req,
  output logic       max_level
);

  state_e     r_state, w_state;
  logic [3:0] r_level, w_level;
  logic [4:0] r_id, w_id;
  logic [7:0] r_acc, w_acc;
  logic [7:0] r_amt, w_amt;
  logic       r_level_up, w_level_up;
  logic [8:0] w_sum;
  logic [7:0] w_thr;
`ifdef EVOLVE_CANCEL_EN
  logic       r_evo_blk, w_evo_blk;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_level    <= 4'd1;
      r_id       <= 5'd0;
      r_acc      <= 8'd0;
      r_amt      <= 8'd0;
      r_level_up <= 1'b0;
`ifdef EVOLVE_CANCEL_EN
      r_evo_blk  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_level    <= w_level;
      r_id       <= w_id;
      r_acc      <= w_acc;
      r_amt      <= w_amt;
      r_level_up <= w_level_up;
`ifdef EVOLVE_CANCEL_EN
      r_evo_blk  <= w_evo_blk;
`endif
    end
  end

  always_comb begin
    w_state    = r_state;
    w_level    = r_level;
    w_id       = r_id;
    w_acc      = r_acc;
    w_amt      = r_amt;
    w_level_up = 1'b0;
`ifdef EVOLVE_CANCEL_EN
    w_evo_blk  = r_evo_blk;
`endif
    w_sum = {1'b0, r_acc} + {1'b0, r_amt};
    w_thr = threshold(r_level);

    if (load_en) begin
      // Load overrides everything, including a same-cycle award.
      w_state = IDLE;
      w_id    = load_ID;
      w_level = (load_level == 4'd0) ? 4'd1 : load_level;
      w_acc   = 8'd0;
`ifdef EVOLVE_CANCEL_EN
      w_evo_blk = 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (xp_valid) begin
            w_amt   = xp_amount;
            w_state = ADD;
          end
        end
        ADD: begin
          w_acc   = w_sum[8] ? 8'hFF : w_sum[7:0];
          w_state = CHECK;
        end
        CHECK: begin
          if (r_level < MAX_LEVEL && r_acc >= w_thr) begin
            w_acc      = r_acc - w_thr;
            w_level    = r_level + 4'd1;
            w_level_up = 1'b1;
`ifdef EVOLVE_CANCEL_EN
            w_evo_blk  = 1'b0;
`endif
            w_state    = EVO_CHECK;
          end else begin
            w_state = IDLE;
          end
        end
        EVO_CHECK: begin
`ifdef EVOLVE_CANCEL_EN
          w_state = (evo_ID != r_id && !r_evo_blk) ? EVOLVE : CHECK;
`else
          w_state = (evo_ID != r_id) ? EVOLVE : CHECK;
`endif
        end
        EVOLVE: begin
          if (evolve_ack) begin
            w_id    = evo_ID;
            w_state = CHECK;
`ifdef EVOLVE_CANCEL_EN
          end else if (evolve_cancel) begin
            w_evo_blk = 1'b1;
            w_state   = CHECK;
`endif
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign xp_ready   = (r_state == IDLE);
  assign evolve_req = (r_state == EVOLVE);
  assign level_up   = r_level_up;
  assign curr_level = r_level;
  assign curr_ID    = r_id;
  assign max_level  = (r_level == MAX_LEVEL);

endmodule

// File: tb/tb_user_level_tracker.sv
// Randomized bench for user_level_tracker against a transaction-level XP/level model.
module tb_user_level_tracker;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       load_en;
  logic [4:0] load_ID;
  logic [3:0] load_level;
  logic       xp_valid;
  logic [7:0] xp_amount;
  logic       xp_ready;
  logic [4:0] evo_ID;
  logic       evolve_ack;
  logic [3:0] curr_level;
  logic [4:0] curr_ID;
  logic       level_up;
  logic       evolve_req;
  logic       max_level;
`ifdef EVOLVE_CANCEL_EN
  logic       evolve_cancel;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int m_lvl, m_id, m_acc, exp_pulses, exp_evos;

  always #5 Clk = ~Clk;

  // External evolution table: 3->6 above level 5, 6->7 above 9, 10->11 above 3.
  function automatic int evo_fn(input int lvl, input int id);
    if (id == 3 && lvl > 5) return 6;
    if (id == 6 && lvl > 9) return 7;
    if (id == 10 && lvl > 3) return 11;
    return id;
  endfunction

  assign evo_ID = 5'(evo_fn(int'(curr_level), int'(curr_ID)));

  user_level_tracker dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .load_en    (load_en),
    .load_ID    (load_ID),
    .load_level (load_level),
    .xp_valid   (xp_valid),
    .xp_amount  (xp_amount),
    .xp_ready   (xp_ready),
    .evo_ID     (evo_ID),
    .evolve_ack (evolve_ack),
`ifdef EVOLVE_CANCEL_EN
    .evolve_cancel (evolve_cancel),
`endif
    .curr_level (curr_level),
    .curr_ID    (curr_ID),
    .level_up   (level_up),
    .evolve_req (evolve_req),
    .max_level  (max_level)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Whole-award outcome from the level rules, assuming every evolution is acknowledged.
  task automatic model_award(input int amt);
    m_acc = m_acc + amt;
    if (m_acc > 255) m_acc = 255;
    exp_pulses = 0;
    exp_evos   = 0;
    while (m_lvl < 15 && m_acc >= 16 * m_lvl) begin
      m_acc = m_acc - 16 * m_lvl;
      m_lvl++;
      exp_pulses++;
      if (evo_fn(m_lvl, m_id) != m_id) begin
        exp_evos++;
        m_id = evo_fn(m_lvl, m_id);
      end
    end
  endtask

  task automatic do_load(input int id, input int lvl);
    @(negedge Clk);
    load_en = 1'b1; load_ID = 5'(id); load_level = 4'(lvl);
    @(negedge Clk);
    load_en = 1'b0;
    m_id = id; m_lvl = (lvl == 0) ? 1 : lvl; m_acc = 0;
    chk("load_level", int'(curr_level), m_lvl);
    chk("load_id", int'(curr_ID), m_id);
    chk("load_req", int'(evolve_req), 0);
  endtask

  // Offers one award; stop_at_evo returns (at a negedge) as soon as evolve_req is seen.
  // ack_wait < 0 picks a random acknowledge delay per request.
  task automatic award(input int amt, input bit stop_at_evo, input int ack_wait);
    int  pulses, evos, first, wcnt, c, w;
    bit  done, prev_req, overlap, seen_req;
    pulses = 0; evos = 0; first = -1; wcnt = 0; c = 0; w = 0;
    done = 0; prev_req = 0; overlap = 0; seen_req = 0;
    @(negedge Clk);
    while (!xp_ready && w < 20) begin
      @(negedge Clk);
      w++;
    end
    chk("ready_before_award", int'(xp_ready), 1);
    if (!stop_at_evo) model_award(amt);
    xp_valid = 1'b1; xp_amount = 8'(amt);
    @(negedge Clk);
    xp_valid = 1'b0;
    while (!done && c < 400) begin
      evolve_ack = 1'b0;
      if (level_up) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (xp_ready && evolve_req) overlap = 1;
      if (evolve_req) begin
        seen_req = 1;
        if (stop_at_evo) done = 1;
        else begin
          if (!prev_req) wcnt = (ack_wait < 0) ? int'($urandom_range(0, 10)) : ack_wait;
          if (wcnt == 0) begin
            evolve_ack = 1'b1;
            evos++;
          end else wcnt--;
        end
      end
      prev_req = evolve_req;
      if (xp_ready && c > 0) done = 1;
      if (!done) begin
        @(negedge Clk);
        c++;
      end
    end
    chk("award_done_in_budget", int'(done), 1);
    if (stop_at_evo) begin
      chk("evo_req_seen", int'(seen_req), 1);
    end else begin
      chk("level_up_count", pulses, exp_pulses);
      chk("evolution_count", evos, exp_evos);
      chk("level_after_award", int'(curr_level), m_lvl);
      chk("id_after_award", int'(curr_ID), m_id);
      chk("max_level_flag", int'(max_level), (m_lvl == 15) ? 1 : 0);
      chk("ready_during_evolve", int'(overlap), 0);
      if (exp_pulses > 0) chk("level_up_latency", first, 2);
    end
  endtask

  initial begin
    int ids[4];
    int pulses;
    ids[0] = 0; ids[1] = 3; ids[2] = 6; ids[3] = 10;
    Reset = 1'b1; load_en = 1'b0; load_ID = 5'd0; load_level = 4'd0;
    xp_valid = 1'b0; xp_amount = 8'd0; evolve_ack = 1'b0;
`ifdef EVOLVE_CANCEL_EN
    evolve_cancel = 1'b0;
`endif
    m_lvl = 1; m_id = 0; m_acc = 0;
    repeat (2) @(negedge Clk);
    chk("rst_level", int'(curr_level), 1);
    chk("rst_id", int'(curr_ID), 0);
    chk("rst_level_up", int'(level_up), 0);
    chk("rst_evolve_req", int'(evolve_req), 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_ready", int'(xp_ready), 1);
    chk("rst_max_level", int'(max_level), 0);

    // 16 XP at level 1: one level, latency checked inside award.
    award(16, 0, -1);
    // 255 XP at level 1 via load: multiple one-per-pass level-ups.
    do_load(0, 1);
    award(255, 0, -1);

    // Evolution acknowledged after 10 cycles.
    do_load(3, 5);
    award(80, 0, 10);

    // Acknowledge outside EVOLVE is ignored even when lookup differs.
    do_load(3, 9);
    @(negedge Clk); evolve_ack = 1'b1;
    @(negedge Clk); evolve_ack = 1'b0;
    @(negedge Clk);
    chk("ack_ignored_idle", int'(curr_ID), 3);

    // Level cap and XP saturation.
    do_load(7, 15);
    award(250, 0, -1);
    award(20, 0, -1);

    // Load plus award during EVOLVE: load wins, award dropped.
    do_load(3, 5);
    award(80, 1, 0);
    load_en = 1'b1; load_ID = 5'd4; load_level = 4'd0;
    xp_valid = 1'b1; xp_amount = 8'd200;
    @(negedge Clk);
    load_en = 1'b0; xp_valid = 1'b0;
    m_lvl = 1; m_id = 4; m_acc = 0;
    chk("evo_load_level", int'(curr_level), 1);
    chk("evo_load_id", int'(curr_ID), 4);
    chk("evo_load_req", int'(evolve_req), 0);
    pulses = 0;
    repeat (5) begin
      @(negedge Clk);
      if (level_up) pulses++;
    end
    chk("dropped_award_pulses", pulses, 0);
    chk("dropped_award_ready", int'(xp_ready), 1);

`ifdef EVOLVE_CANCEL_EN
    do_load(3, 5);
    award(80, 1, 0);
    evolve_cancel = 1'b1;
    @(negedge Clk);
    evolve_cancel = 1'b0;
    chk("cancel_id_kept", int'(curr_ID), 3);
    chk("cancel_req_drop", int'(evolve_req), 0);
    pulses = 0;
    repeat (4) begin
      @(negedge Clk);
      if (evolve_req) pulses++;
    end
    chk("cancel_no_rerequest", pulses, 0);
    award(96, 1, 0);
    evolve_ack = 1'b1;
    @(negedge Clk);
    evolve_ack = 1'b0;
    chk("cancel_then_evolve_id", int'(curr_ID), 6);
    m_lvl = 7; m_id = 6; m_acc = 0;
`endif

    // Reset during EVOLVE abandons the evolution.
    do_load(3, 5);
    award(80, 1, 0);
    #2 Reset = 1'b1;
    #1;
    chk("rst_mid_evo_req", int'(evolve_req), 0);
    chk("rst_mid_evo_id", int'(curr_ID), 0);
    chk("rst_mid_evo_level", int'(curr_level), 1);
    @(negedge Clk);
    Reset = 1'b0;
    m_lvl = 1; m_id = 0; m_acc = 0;

    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 5));
      if (r == 0) do_load(ids[$urandom_range(0, 3)], int'($urandom_range(0, 15)));
      if (r == 1) begin
        @(negedge Clk); evolve_ack = 1'b1;
        @(negedge Clk); evolve_ack = 1'b0;
        chk("rand_ack_idle_id", int'(curr_ID), m_id);
      end
      award(int'($urandom_range(0, 255)), 0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
